// File: rtl/rx_ds_receiver.sv
// rx_ds_receiver: Data/Strobe link receiver. Synchronizes D/S, recovers one bit per transition
// and reassembles data/control characters onto a valid/ready port. Parity check: RX_DS_PARITY_CHECK_EN.
module rx_ds_receiver #(
  parameter int SYNC_STAGES = 2,
  parameter int DISC_CYCLES = 64
) (
  input  logic       RxClk,
  input  logic       RxReset,
  input  logic       d,
  input  logic       s,
  output logic [7:0] dat_o,
  output logic       lchar_o,
  output logic       valid_o,
  input  logic       ready_i,
  output logic       parity_err_o,
  output logic       overrun_o,
  output logic       ds_err_o,
  output logic       disconnect_o
);
  localparam int CW = $clog2(DISC_CYCLES + 1);

  typedef enum logic [1:0] {HUNT, PARITY, FLAG, PAYLOAD} state_t;

  state_t                 state, state_nxt;
  logic [SYNC_STAGES-1:0] d_sync, s_sync;
  logic                   d_q, s_q;
  logic                   d_chg, s_chg, trans;
  logic                   bit_p0, vld_p0, dserr_p0;
  logic                   armed;
  logic [CW-1:0]          disc_cnt;
  logic                   timeout;
  logic                   flag_q;
  logic [2:0]             bit_idx;
  logic [7:0]             shreg, pay_nxt;
  logic                   take_flag, take_bit, char_done;

  assign d_chg   = d_sync[SYNC_STAGES-1] ^ d_q;
  assign s_chg   = s_sync[SYNC_STAGES-1] ^ s_q;
  assign trans   = d_chg | s_chg;
  // Expiry is decided on the same edge the counter would step from 1 to 0.
  assign timeout = armed & ~trans & (disc_cnt == CW'(1));

  // Stage p0: synchronize, detect transitions against history, register the recovered bit.
  always_ff @(posedge RxClk or posedge RxReset) begin
    if (RxReset) begin
      d_sync       <= '0;
      s_sync       <= '0;
      d_q          <= 1'b0;
      s_q          <= 1'b0;
      bit_p0       <= 1'b0;
      vld_p0       <= 1'b0;
      dserr_p0     <= 1'b0;
      armed        <= 1'b0;
      disc_cnt     <= CW'(DISC_CYCLES);
      disconnect_o <= 1'b0;
    end else begin
      d_sync   <= {d_sync[SYNC_STAGES-2:0], d};
      s_sync   <= {s_sync[SYNC_STAGES-2:0], s};
      d_q      <= d_sync[SYNC_STAGES-1];
      s_q      <= s_sync[SYNC_STAGES-1];
      bit_p0   <= d_sync[SYNC_STAGES-1];
      vld_p0   <= trans & ~(d_chg & s_chg);
      dserr_p0 <= d_chg & s_chg;
      if (trans) begin
        armed        <= 1'b1;
        disc_cnt     <= CW'(DISC_CYCLES);
        disconnect_o <= 1'b0;
      end else if (armed && disc_cnt != '0) begin
        disc_cnt <= disc_cnt - CW'(1);
        if (timeout) disconnect_o <= 1'b1;
      end
    end
  end

  // Stage p1: character framing state machine.
  always_ff @(posedge RxClk or posedge RxReset) begin
    if (RxReset) state <= HUNT;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    take_flag = 1'b0;
    take_bit  = 1'b0;
    char_done = 1'b0;
    if (timeout || dserr_p0) begin
      state_nxt = HUNT;
    end else if (vld_p0) begin
      unique case (state)
        HUNT, PARITY: state_nxt = FLAG;
        FLAG: begin
          take_flag = 1'b1;
          state_nxt = PAYLOAD;
        end
        PAYLOAD: begin
          take_bit = 1'b1;
          if (bit_idx == (flag_q ? 3'd1 : 3'd7)) begin
            char_done = 1'b1;
            state_nxt = PARITY;
          end
        end
        default: state_nxt = HUNT;
      endcase
    end
  end

  always_comb begin
    pay_nxt          = shreg;
    pay_nxt[bit_idx] = bit_p0;
  end

  always_ff @(posedge RxClk or posedge RxReset) begin
    if (RxReset) begin
      flag_q    <= 1'b0;
      bit_idx   <= 3'd0;
      shreg     <= 8'd0;
      dat_o     <= 8'd0;
      lchar_o   <= 1'b0;
      valid_o   <= 1'b0;
      overrun_o <= 1'b0;
      ds_err_o  <= 1'b0;
    end else begin
      ds_err_o  <= dserr_p0;
      overrun_o <= 1'b0;
      if (take_flag) begin
        flag_q  <= bit_p0;
        bit_idx <= 3'd0;
        shreg   <= 8'd0;
      end else if (take_bit) begin
        shreg   <= pay_nxt;
        bit_idx <= bit_idx + 3'd1;
      end
      if (char_done && valid_o && !ready_i) begin
        overrun_o <= 1'b1;
      end else if (char_done) begin
        dat_o   <= pay_nxt;
        lchar_o <= flag_q;
        valid_o <= 1'b1;
      end else if (valid_o && ready_i) begin
        valid_o <= 1'b0;
      end
    end
  end

`ifdef RX_DS_PARITY_CHECK_EN
  logic par_bit, par_acc, first_char, take_par, par_err;

  function automatic logic odd_ok(input logic acc, input logic flag, input logic par);
    return acc ^ flag ^ par;
  endfunction

  assign take_par = vld_p0 & ~dserr_p0 & ~timeout & ((state == HUNT) | (state == PARITY));
  // The flag bit is covered by parity, so the check resolves when the flag arrives.
  assign par_err  = take_flag & ~first_char & ~odd_ok(par_acc, bit_p0, par_bit);

  always_ff @(posedge RxClk or posedge RxReset) begin
    if (RxReset) begin
      par_bit      <= 1'b0;
      par_acc      <= 1'b0;
      first_char   <= 1'b0;
      parity_err_o <= 1'b0;
    end else begin
      parity_err_o <= par_err;
      if (take_par) begin
        par_bit    <= bit_p0;
        first_char <= (state == HUNT);
      end
      if (take_flag)     par_acc <= 1'b0;
      else if (take_bit) par_acc <= par_acc ^ bit_p0;
    end
  end
`else
  assign parity_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_rx_ds_receiver.sv
// tb_rx_ds_receiver: randomized DS-line stimulus with a queue scoreboard; expected characters
// and parity bits come from a character-level model of the link.
module tb_rx_ds_receiver;
  localparam int SYNC_STAGES = 2;
  localparam int DISC_CYCLES = 64;
`ifdef RX_DS_PARITY_CHECK_EN
  localparam int PCHK = 1;
`else
  localparam int PCHK = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       d = 1'b0;
  logic       s = 1'b0;
  logic       ready = 1'b0;
  logic [7:0] dat;
  logic       lchar, valid, perr, ovr, dserr, disc;

  int total = 0;
  int bad = 0;
  int n_perr = 0, n_ovr = 0, n_dserr = 0;
  int exp_perr = 0, exp_ovr = 0, exp_dserr = 0;
  logic [8:0] exp_q[$];
  logic [8:0] mon_e;
  logic       prev_xor = 1'b0;

  always #5 clk = ~clk;

  rx_ds_receiver #(.SYNC_STAGES(SYNC_STAGES), .DISC_CYCLES(DISC_CYCLES)) dut (
    .RxClk(clk), .RxReset(rst), .d(d), .s(s),
    .dat_o(dat), .lchar_o(lchar), .valid_o(valid), .ready_i(ready),
    .parity_err_o(perr), .overrun_o(ovr), .ds_err_o(dserr), .disconnect_o(disc)
  );

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard on every accepted character and counts error pulses.
  always @(negedge clk) begin
    if (!rst) begin
      if (valid && ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_char: got lchar=%0d dat=0x%02h expected none", lchar, dat);
        end else begin
          mon_e = exp_q.pop_front();
          check("char_dat", int'(dat), int'(mon_e[7:0]));
          check("char_lchar", int'(lchar), int'(mon_e[8]));
        end
      end
      if (perr)  n_perr++;
      if (ovr)   n_ovr++;
      if (dserr) n_dserr++;
    end
  end

  function automatic int rnd_hold();
    return int'($urandom_range(4, 2));
  endfunction

  // One DS bit: D carries the bit, S toggles when D does not.
  task automatic send_bit(input logic b, input int hold);
    if (b != d) d = b;
    else        s = ~s;
    if (hold > 0) begin
      repeat (hold) @(posedge clk);
      #1;
    end
  endtask

  task automatic send_char(input logic flag, input logic [7:0] pay, input logic badpar,
                           input logic deliver);
    logic px;
    int   n;
    px = 1'b0;
    n  = flag ? 2 : 8;
    for (int i = 0; i < n; i++) px ^= pay[i];
    send_bit(1'b1 ^ flag ^ prev_xor ^ badpar, rnd_hold());
    send_bit(flag, rnd_hold());
    if (deliver) exp_q.push_back({flag, flag ? {6'b0, pay[1:0]} : pay});
    for (int i = 0; i < n; i++) send_bit(pay[i], rnd_hold());
    prev_xor = px;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 30 && exp_q.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    check(name, exp_q.size(), 0);
  endtask

  task automatic check_errs(input string tag);
    check({tag, "_parity_err"}, n_perr, exp_perr);
    check({tag, "_overrun"}, n_ovr, exp_ovr);
    check({tag, "_ds_err"}, n_dserr, exp_dserr);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected test end");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_dat", int'(dat), 0);
    check("rst_lchar", int'(lchar), 0);
    check("rst_valid", int'(valid), 0);
    check("rst_parity_err", int'(perr), 0);
    check("rst_overrun", int'(ovr), 0);
    check("rst_ds_err", int'(dserr), 0);
    check("rst_disconnect", int'(disc), 0);
    rst   = 1'b0;
    ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    send_char(1'b0, 8'hA5, 1'b0, 1'b1);
    wait_drain("drain_a5");
    check_errs("a5");

    send_char(1'b1, 8'h02, 1'b0, 1'b1);
    send_char(1'b0, 8'h3C, 1'b0, 1'b1);
    wait_drain("drain_ctl");

    send_char(1'b0, 8'h00, 1'b0, 1'b1);
    send_char(1'b0, 8'hFF, 1'b1, 1'b1);
    exp_perr += PCHK;
    wait_drain("drain_badpar");
    check_errs("badpar");

    for (int i = 0; i < 12; i++)
      send_char(1'($urandom_range(1, 0)), 8'($urandom), 1'b0, 1'b1);
    wait_drain("drain_rand1");
    check_errs("rand1");

    ready = 1'b0;
    send_char(1'b0, 8'h11, 1'b0, 1'b1);
    send_char(1'b0, 8'h22, 1'b0, 1'b0);
    exp_ovr++;
    repeat (5) @(posedge clk);
    #1;
    check("ovr_count", n_ovr, exp_ovr);
    check("ovr_held_dat", int'(dat), 8'h11);
    check("ovr_held_valid", int'(valid), 1);
    ready = 1'b1;
    wait_drain("drain_ovr");
    @(posedge clk);
    #1;
    check("ovr_valid_clear", int'(valid), 0);

    // Partial character then silence: parity and flag valid, four payload bits.
    send_bit(1'b1 ^ prev_xor, rnd_hold());
    send_bit(1'b0, rnd_hold());
    for (int i = 0; i < 3; i++) send_bit(1'($urandom_range(1, 0)), rnd_hold());
    send_bit(1'b1, 0);
    repeat (SYNC_STAGES + DISC_CYCLES) @(posedge clk);
    #1;
    check("disc_before", int'(disc), 0);
    @(posedge clk);
    #1;
    check("disc_rise", int'(disc), 1);
    check("disc_no_valid", int'(valid), 0);
    send_bit(1'b1 ^ prev_xor, 0);
    repeat (SYNC_STAGES + 1) @(posedge clk);
    #1;
    check("disc_drop", int'(disc), 0);
    send_bit(1'b0, rnd_hold());
    exp_q.push_back({1'b0, 8'h5A});
    for (int i = 0; i < 8; i++) send_bit(1'(8'h5A >> i), rnd_hold());
    prev_xor = 1'b0;
    wait_drain("drain_5a");
    check_errs("disc");

    // Partial character broken by a simultaneous D and S change.
    send_bit(1'b1 ^ prev_xor, rnd_hold());
    send_bit(1'b0, rnd_hold());
    for (int i = 0; i < 3; i++) send_bit(1'($urandom_range(1, 0)), rnd_hold());
    d = ~d;
    s = ~s;
    exp_dserr++;
    repeat (4) @(posedge clk);
    #1;
    send_char(1'b0, 8'h81, 1'b0, 1'b1);
    wait_drain("drain_81");
    check_errs("dserr");

    for (int i = 0; i < 12; i++)
      send_char(1'($urandom_range(1, 0)), 8'($urandom), 1'b0, 1'b1);
    wait_drain("drain_rand2");
    repeat (4) @(posedge clk);
    #1;
    check_errs("final");
    check("final_disc", int'(disc), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
